// File: rtl/rf_arb_pkg.sv
// Shared encodings and widths for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_hold_entry.sv
// One-entry holding register for a deferred Aux writeback result.
module rf_hold_entry
  import rf_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [REG_ADDR_W-1:0] i_reg,
  input  logic [N-1:0]          i_data,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_reg,
  output logic [N-1:0]          o_data
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_reg;
  logic [N-1:0]          r_data;

  // NOTE: a single entry is cheap to reset, so address and data are cleared
  // with valid; nothing stale can ever reach Pending_Register_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_reg   <= ZERO_REG;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_reg   <= i_reg;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_reg   <= ZERO_REG;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_reg   = r_reg;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (priority)
// and a buffered auxiliary result, with a starvation-forced drain.
module regfile_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Pipe_Write_i,
  input  logic [REG_ADDR_W-1:0] Pipe_Register_i,
  input  logic [N-1:0]          Pipe_Data_i,
  output logic                  Pipe_Stall_o,
  input  logic                  Aux_Valid_i,
  input  logic [REG_ADDR_W-1:0] Aux_Register_i,
  input  logic [N-1:0]          Aux_Data_i,
  output logic                  Aux_Ready_o,
  output logic                  Reg_Write_o,
  output logic [REG_ADDR_W-1:0] Write_Register_o,
  output logic [N-1:0]          Write_Data_o,
  output logic                  Pending_Valid_o,
  output logic [REG_ADDR_W-1:0] Pending_Register_o
);

  arb_state_e            r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic                  w_pipe_eff;
  logic                  w_hold_load, w_hold_clear;
  logic                  w_hold_valid;
  logic [REG_ADDR_W-1:0] w_hold_reg;
  logic [N-1:0]          w_hold_data;
  logic                  w_wr_en;
  logic [REG_ADDR_W-1:0] w_wr_reg;
  logic [N-1:0]          w_wr_data;

  rf_hold_entry #(.N(N)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_reg   (Aux_Register_i),
    .i_data  (Aux_Data_i),
    .o_valid (w_hold_valid),
    .o_reg   (w_hold_reg),
    .o_data  (w_hold_data)
  );

  // A write to x0 or one made during a forced drain never reaches the port.
  assign w_pipe_eff = Pipe_Write_i && (Pipe_Register_i != ZERO_REG) && (r_state != FORCE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_reg     = ZERO_REG;
    w_wr_data    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pipe_eff) begin
          w_wr_en   = 1'b1;
          w_wr_reg  = Pipe_Register_i;
          w_wr_data = Pipe_Data_i;
        end
        if (Aux_Valid_i && (Aux_Register_i != ZERO_REG)) begin
          w_hold_load  = 1'b1;
          w_state_next = WAIT;
          w_cnt_next   = '0;
        end
      end
      WAIT: begin
        w_wr_en = 1'b1;
        if (!w_pipe_eff) begin
          w_wr_reg     = w_hold_reg;
          w_wr_data    = w_hold_data;
          w_hold_clear = 1'b1;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_wr_reg  = Pipe_Register_i;
          w_wr_data = Pipe_Data_i;
          // The pipeline value is younger, so a same-register hold is obsolete.
          if (Pipe_Register_i == w_hold_reg) begin
            w_hold_clear = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
            w_state_next = FORCE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      FORCE: begin
        w_wr_en      = 1'b1;
        w_wr_reg     = w_hold_reg;
        w_wr_data    = w_hold_data;
        w_hold_clear = 1'b1;
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_hold_clear = 1'b1;
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are forced low for the whole reset pulse, including pipe pass-through.
  assign Reg_Write_o        = !reset && w_wr_en;
  assign Write_Register_o   = reset ? ZERO_REG : w_wr_reg;
  assign Write_Data_o       = reset ? '0 : w_wr_data;
  assign Pipe_Stall_o       = !reset && (r_state == FORCE);
  assign Aux_Ready_o        = !reset && (r_state == IDLE);
  assign Pending_Valid_o    = !reset && w_hold_valid;
  assign Pending_Register_o = Pending_Valid_o ? w_hold_reg : ZERO_REG;

endmodule
